// File: rtl/accum_seq_pkg.sv
// Shared types and constants for the accumulate/step sequencer.
package accum_seq_pkg;

  // Default datapath width for x, y, limit and step counters
  localparam int W_DEF = 8;

  // Termination reason codes reported on o_reason
  localparam logic REASON_LIMIT  = 1'b0;
  localparam logic REASON_BUDGET = 1'b1;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/accum_step.sv
// x/y datapath: holds the two registers and performs one step
// x <= x + y (low W bits), y <= x, exposing the carry out of the adder.
module accum_step
  import accum_seq_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [W-1:0] i_init_x,
  input  logic [W-1:0] i_init_y,
  output logic [W-1:0] o_x,
  output logic [W-1:0] o_y,
  output logic         o_carry
);

  logic [W-1:0] r_x;
  logic [W-1:0] r_y;
  logic [W:0]   w_sum;

  // One bit wider than the operands so bit W is the carry
  assign w_sum   = {1'b0, r_x} + {1'b0, r_y};
  assign o_carry = w_sum[W];
  assign o_x     = r_x;
  assign o_y     = r_y;

  // Seed on load, advance on step, otherwise hold (abort freezes values)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x <= W'(1);
      r_y <= W'(1);
    end else if (i_load) begin
      r_x <= i_init_x;
      r_y <= i_init_y;
    end else if (i_step) begin
      r_x <= w_sum[W-1:0];
      r_y <= r_x;
    end
  end

endmodule

// File: rtl/accum_seq_ctrl.sv
// Sequencer top: FSM, step counter, limit/budget latches and result flags
// around the accum_step datapath.
module accum_seq_ctrl
  import accum_seq_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [W-1:0] i_init_x,
  input  logic [W-1:0] i_init_y,
  input  logic [W-1:0] i_limit,
  input  logic [W-1:0] i_max_steps,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_x_out,
  output logic [W-1:0] o_y_out,
  output logic [W-1:0] o_steps,
  output logic         o_reason,
  output logic         o_ovf
);

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_limit;
  logic [W-1:0] r_max;
  logic [W-1:0] r_steps;
  logic         r_reason;
  logic         r_ovf;

  logic         w_load;
  logic         w_step;
  logic         w_set_budget;
  logic         w_carry;
  logic         w_at_limit;
  logic         w_at_budget;
  logic [W-1:0] w_x;
  logic [W-1:0] w_y;

  accum_step #(.W(W)) u_step (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_init_x (i_init_x),
    .i_init_y (i_init_y),
    .o_x      (w_x),
    .o_y      (w_y),
    .o_carry  (w_carry)
  );

  assign w_at_limit  = (w_x >= r_limit);
  assign w_at_budget = (r_steps == r_max);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: abort outranks everything; limit is checked before budget
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (i_start && !i_abort) w_next = S_LOAD;
      S_LOAD: w_next = i_abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (i_abort)                        w_next = S_IDLE;
        else if (w_at_limit || w_at_budget) w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs and datapath strobes decoded from the current state
  always_comb begin
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_set_budget = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        o_busy = 1'b1;
        w_load = !i_abort;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (!i_abort && !w_at_limit) begin
          if (w_at_budget) w_set_budget = 1'b1;
          else             w_step       = 1'b1;
        end
      end
      S_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Step counter and sticky result flags; cleared on load, held otherwise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_steps  <= '0;
      r_reason <= REASON_LIMIT;
      r_ovf    <= 1'b0;
    end else if (w_load) begin
      r_steps  <= '0;
      r_reason <= REASON_LIMIT;
      r_ovf    <= 1'b0;
    end else begin
      if (w_step) begin
        r_steps <= r_steps + W'(1);
        r_ovf   <= r_ovf | w_carry;
      end
      if (w_set_budget) r_reason <= REASON_BUDGET;
    end
  end

  // Run parameters are only meaningful after a load, so they need no reset
  always_ff @(posedge i_clk) begin
    if (w_load) begin
      r_limit <= i_limit;
      r_max   <= i_max_steps;
    end
  end

  assign o_x_out  = w_x;
  assign o_y_out  = w_y;
  assign o_steps  = r_steps;
  assign o_reason = r_reason;
  assign o_ovf    = r_ovf;

endmodule
